rpn_stack_engine: RTL and testbench

Reverse-Polish evaluation stage directly downstream of the keypad decoder and number builder. It consumes decoded operator tokens together with the number builder's current operand, maintains a fixed-depth operand stack, and executes add/subtract/multiply (and optionally divide). The stack top drives the seven-segment display path. The engine pulses a clear back to the number builder after each push.

---
 rtl/rpn_stack_engine.sv | 210 +++++++++++++++++++++
 tb/tb_rpn_stack_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_engine.sv
// Reverse-Polish operand stack and arithmetic engine behind the keypad number builder.
// Optional restoring divider for token 0xF is compiled in with `define STACK_DIV_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | token_ready high; captures operator token and operand on accept
// EXEC  | single-cycle execute of enter/clear/add/sub/mul and error cases
// DIV   | one restoring quotient bit per cycle, DW cycles, then write-back
module rpn_stack_engine #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          token_valid,
    input  logic [3:0]    token,
    input  logic [DW-1:0] operand,
    output logic          token_ready,
    output logic          nb_clear,
    output logic [DW-1:0] top,
    output logic [4:0]    depth,
    output logic          err_underflow,
    output logic          err_overflow,
    output logic          err_illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'hA;
    localparam logic [3:0] OP_SUB   = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_ENTER = 4'hD;
    localparam logic [3:0] OP_CLR   = 4'hE;
    localparam logic [3:0] OP_DIV   = 4'hF;

    localparam logic [4:0] DEPTH_L  = 5'(DEPTH);

    logic [1:0]    r_state;
    logic [DW-1:0] r_stack [DEPTH];
    logic [DW-1:0] r_top;
    logic [4:0]    r_depth;
    logic [3:0]    r_tok;
    logic [DW-1:0] r_opnd;
    logic          r_nb_clear;
    logic          r_err_underflow;
    logic          r_err_overflow;
    logic          r_err_illegal;

    logic          w_accept;
    logic          w_is_op;
    logic          w_div_go;
    logic [AW-1:0] w_push_idx;
    logic [AW-1:0] w_nxt_idx;
    logic [DW-1:0] w_below;
    logic [DW-1:0] w_alu;

    assign w_accept   = token_valid && (r_state == S_IDLE);
    assign w_is_op    = (token >= OP_ADD);
    assign w_push_idx = AW'(r_depth);
    assign w_nxt_idx  = AW'(r_depth - 5'd2);
    assign w_below    = r_stack[w_nxt_idx];

    // a is the entry below top, b is top
    always_comb begin
        w_alu = '0;
        case (r_tok)
            OP_ADD:  w_alu = w_below + r_top;
            OP_SUB:  w_alu = w_below - r_top;
            OP_MUL:  w_alu = w_below * r_top;
            default: w_alu = '0;
        endcase
    end

`ifdef STACK_DIV_EN
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [DW-1:0] r_dvs;
    logic [CW-1:0] r_div_cnt;

    logic [DW:0]   w_shift;
    logic [DW:0]   w_diff;
    logic          w_qbit;
    logic [DW-1:0] w_rem_nxt;
    logic [DW-1:0] w_quo_nxt;

    assign w_div_go  = w_accept && (token == OP_DIV) && (r_depth >= 5'd2) && (r_top != '0);
    assign w_shift   = {r_rem, r_quo[DW-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[DW];
    assign w_rem_nxt = w_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
    assign w_quo_nxt = {r_quo[DW-2:0], w_qbit};

    // r_quo starts as the dividend and fills with quotient bits from the LSB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_div_cnt <= '0;
        end else if (w_div_go) begin
            r_rem     <= '0;
            r_quo     <= w_below;
            r_dvs     <= r_top;
            r_div_cnt <= CW'(DW - 1);
        end else if (r_state == S_DIV) begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_div_cnt <= r_div_cnt - 1'b1;
        end
    end
`else
    assign w_div_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
            r_top           <= '0;
            r_depth         <= '0;
            r_tok           <= '0;
            r_opnd          <= '0;
            r_nb_clear      <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_illegal   <= 1'b0;
        end else begin
            r_nb_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_op) begin
                        r_tok   <= token;
                        r_opnd  <= operand;
                        r_state <= w_div_go ? S_DIV : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    case (r_tok)
                        OP_ENTER: begin
                            if (r_depth < DEPTH_L) begin
                                r_stack[w_push_idx] <= r_opnd;
                                r_top               <= r_opnd;
                                r_depth             <= r_depth + 5'd1;
                                r_nb_clear          <= 1'b1;
                            end else begin
                                r_err_overflow <= 1'b1;
                            end
                        end
                        OP_CLR: begin
                            r_depth         <= '0;
                            r_top           <= '0;
                            r_err_underflow <= 1'b0;
                            r_err_overflow  <= 1'b0;
                            r_err_illegal   <= 1'b0;
                            r_nb_clear      <= 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (r_depth < 5'd2) begin
                                r_err_underflow <= 1'b1;
                            end else begin
                                r_stack[w_nxt_idx] <= w_alu;
                                r_top              <= w_alu;
                                r_depth            <= r_depth - 5'd1;
                            end
                        end
                        OP_DIV: begin
`ifdef STACK_DIV_EN
                            // only rejected divides land here: short stack or zero divisor
                            if (r_depth < 5'd2) r_err_underflow <= 1'b1;
                            else                r_err_illegal   <= 1'b1;
`else
                            r_err_illegal <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                S_DIV: begin
`ifdef STACK_DIV_EN
                    if (r_div_cnt == '0) begin
                        r_stack[w_nxt_idx] <= w_quo_nxt;
                        r_top              <= w_quo_nxt;
                        r_depth            <= r_depth - 5'd1;
                        r_state            <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign token_ready   = (r_state == S_IDLE);
    assign nb_clear      = r_nb_clear;
    assign top           = r_top;
    assign depth         = r_depth;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;
    assign err_illegal   = r_err_illegal;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed-vector bench for rpn_stack_engine (DEPTH=8, DW=32); divide cases follow STACK_DIV_EN.
module tb_rpn_stack_engine;

    logic        clk;
    logic        reset_n;
    logic        token_valid;
    logic [3:0]  token;
    logic [31:0] operand;
    logic        token_ready;
    logic        nb_clear;
    logic [31:0] top;
    logic [4:0]  depth;
    logic        err_underflow;
    logic        err_overflow;
    logic        err_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    rpn_stack_engine #(.DEPTH(8), .DW(32)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .token_valid   (token_valid),
        .token         (token),
        .operand       (operand),
        .token_ready   (token_ready),
        .nb_clear      (nb_clear),
        .top           (top),
        .depth         (depth),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_illegal   (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe one token; returns at the negedge after the execute edge.
    task automatic do_op(input logic [3:0] tok, input logic [31:0] opnd,
                         output logic rdy_mid, output logic nbc);
        @(negedge clk);
        token_valid = 1'b1;
        token       = tok;
        operand     = opnd;
        @(negedge clk);
        token_valid = 1'b0;
        operand     = 32'hDEAD_BEEF;
        rdy_mid     = token_ready;
        @(negedge clk);
        nbc         = nb_clear;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp_uoi);
        check(tag, {29'd0, err_underflow, err_overflow, err_illegal}, {29'd0, exp_uoi});
    endtask

    logic rdy;
    logic nbc;
    int   cnt;

    initial begin
        reset_n     = 1'b0;
        token_valid = 1'b0;
        token       = 4'h0;
        operand     = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_top", top, 32'd0);
        check("rst_depth", {27'd0, depth}, 32'd0);
        check_flags("rst_flags", 3'b000);
        check("rst_ready", {31'd0, token_ready}, 32'd1);
        check("rst_nbclr", {31'd0, nb_clear}, 32'd0);

        // 12 + 30
        do_op(4'hD, 32'd12, rdy, nbc);
        check("enter1_ready_low", {31'd0, rdy}, 32'd0);
        check("enter1_nbclr", {31'd0, nbc}, 32'd1);
        check("enter1_top", top, 32'd12);
        @(negedge clk);
        check("enter1_nbclr_1cyc", {31'd0, nb_clear}, 32'd0);
        do_op(4'hD, 32'd30, rdy, nbc);
        check("enter2_nbclr", {31'd0, nbc}, 32'd1);
        check("enter2_depth", {27'd0, depth}, 32'd2);
        do_op(4'hA, 32'd0, rdy, nbc);
        check("add_top", top, 32'd42);
        check("add_depth", {27'd0, depth}, 32'd1);
        check("add_no_nbclr", {31'd0, nbc}, 32'd0);

        // digit tokens are ignored
        do_op(4'h5, 32'd99, rdy, nbc);
        check("digit_top", top, 32'd42);
        check("digit_depth", {27'd0, depth}, 32'd1);

        // 3 - 5 wraps
        do_op(4'hE, 32'd0, rdy, nbc);
        check("clr_nbclr", {31'd0, nbc}, 32'd1);
        check("clr_depth", {27'd0, depth}, 32'd0);
        check("clr_top", top, 32'd0);
        do_op(4'hD, 32'd3, rdy, nbc);
        do_op(4'hD, 32'd5, rdy, nbc);
        do_op(4'hB, 32'd0, rdy, nbc);
        check("sub_wrap", top, 32'hFFFF_FFFE);
        check("sub_depth", {27'd0, depth}, 32'd1);

        // multiply truncation and full-width product
        do_op(4'hE, 32'd0, rdy, nbc);
        do_op(4'hD, 32'h0001_0000, rdy, nbc);
        do_op(4'hD, 32'h0001_0000, rdy, nbc);
        do_op(4'hC, 32'd0, rdy, nbc);
        check("mul_trunc", top, 32'd0);
        do_op(4'hE, 32'd0, rdy, nbc);
        do_op(4'hD, 32'h0000_FFFF, rdy, nbc);
        do_op(4'hD, 32'h0001_0001, rdy, nbc);
        do_op(4'hC, 32'd0, rdy, nbc);
        check("mul_full", top, 32'hFFFF_FFFF);

        // fill to DEPTH, then overflow
        do_op(4'hE, 32'd0, rdy, nbc);
        for (int i = 1; i <= 8; i++) do_op(4'hD, i, rdy, nbc);
        check("fill_depth", {27'd0, depth}, 32'd8);
        check("fill_top", top, 32'd8);
        check_flags("fill_flags", 3'b000);
        do_op(4'hD, 32'd77, rdy, nbc);
        check("ovf_depth", {27'd0, depth}, 32'd8);
        check("ovf_top", top, 32'd8);
        check("ovf_no_nbclr", {31'd0, nbc}, 32'd0);
        check_flags("ovf_flags", 3'b010);
        do_op(4'hA, 32'd0, rdy, nbc);
        check("ovf_sticky_add", top, 32'd15);
        check("ovf_sticky_depth", {27'd0, depth}, 32'd7);
        check_flags("ovf_sticky_flags", 3'b010);
        do_op(4'hE, 32'd0, rdy, nbc);
        check("clr2_depth", {27'd0, depth}, 32'd0);
        check_flags("clr2_flags", 3'b000);

        // underflow on empty stack
        do_op(4'hA, 32'd0, rdy, nbc);
        check_flags("unf_flags", 3'b100);
        check("unf_depth", {27'd0, depth}, 32'd0);
        check("unf_top", top, 32'd0);

        // clear strobed while busy must be dropped
        @(negedge clk);
        token_valid = 1'b1;
        token       = 4'hD;
        operand     = 32'd7;
        @(negedge clk);
        check("busy_ready_low", {31'd0, token_ready}, 32'd0);
        token       = 4'hE;
        @(negedge clk);
        token_valid = 1'b0;
        @(negedge clk);
        check("drop_depth", {27'd0, depth}, 32'd1);
        check("drop_top", top, 32'd7);
        check_flags("drop_flags", 3'b100);

        // underflow with a single entry leaves it intact
        do_op(4'hB, 32'd0, rdy, nbc);
        check("unf1_depth", {27'd0, depth}, 32'd1);
        check("unf1_top", top, 32'd7);

        // divide
        do_op(4'hE, 32'd0, rdy, nbc);
        do_op(4'hD, 32'd100, rdy, nbc);
        do_op(4'hD, 32'd7, rdy, nbc);
`ifdef STACK_DIV_EN
        @(negedge clk);
        token_valid = 1'b1;
        token       = 4'hF;
        @(negedge clk);
        token_valid = 1'b0;
        cnt = 0;
        while (!token_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("div_busy_cycles", cnt, 32'd32);
        check("div_quot", top, 32'd14);
        check("div_depth", {27'd0, depth}, 32'd1);
        check_flags("div_flags", 3'b000);
        do_op(4'hD, 32'd0, rdy, nbc);
        do_op(4'hF, 32'd0, rdy, nbc);
        check("div0_ready_1cyc", {31'd0, rdy}, 32'd0);
        check_flags("div0_flags", 3'b001);
        check("div0_depth", {27'd0, depth}, 32'd2);
        check("div0_top", top, 32'd0);
`else
        do_op(4'hF, 32'd0, rdy, nbc);
        check("nodiv_ready_1cyc", {31'd0, rdy}, 32'd0);
        check_flags("nodiv_flags", 3'b001);
        check("nodiv_depth", {27'd0, depth}, 32'd2);
        check("nodiv_top", top, 32'd7);
`endif
        do_op(4'hE, 32'd0, rdy, nbc);
        check_flags("final_clr_flags", 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
